bus_arbiter8: RTL and testbench



---
 rtl/bus_arbiter8_pkg.sv | 19 +
 rtl/DMux8Way.sv | 24 ++
 rtl/Mux8Way16.sv | 30 +++
 rtl/bus_arbiter8_rr_pick.sv | 29 ++
 rtl/bus_arbiter8.sv | 131 +++++++++++++
 tb/tb_bus_arbiter8.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/bus_arbiter8_pkg.sv
// Shared constants, state encoding and data_in slicing helper for the
// 8-way round-robin bus arbiter.
package bus_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int W     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Requester i owns bits [W*i +: W] of the packed data_in bus.
  function automatic logic [W-1:0] word_of(input logic [N_REQ*W-1:0] data,
                                           input logic [2:0]         idx);
    return data[idx*W +: W];
  endfunction

endpackage

// File: rtl/DMux8Way.sv
// 1-bit 8-way demultiplexer: routes 'in' to the output selected by sel.
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);

endmodule

// File: rtl/Mux8Way16.sv
// 8-way 16-bit word multiplexer from the shared datapath primitive set.
module Mux8Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/bus_arbiter8_rr_pick.sv
// Round-robin pick: first set bit of req searching ptr+1 .. ptr+8 (mod 8).
module rr_pick (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] idx,
  output logic       any
);

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [3:0]  shamt;
  logic [2:0]  off;

  // Rotate so the candidate after ptr lands at bit 0, encode, rotate back.
  assign shamt = {1'b0, ptr} + 4'd1;
  assign dbl   = {req, req} >> shamt;
  assign rot   = dbl[7:0];
  assign any   = |req;

  always_comb begin
    off = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (rot[j]) off = 3'(j);
    end
  end

  assign idx = ptr + 3'd1 + off;

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one 16-bit bus among 8 requesters with a
// bounded burst per grant and a registered output word.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data_in,
  output logic [N_REQ-1:0]   grant,
  output logic               gnt_valid,
  output logic [2:0]         gnt_idx,
  output logic [W-1:0]       out,
  output logic               out_valid
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [2:0]     gnt_idx_q, gnt_idx_d;
  logic [W-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;

  logic [2:0]     pick_ptr;
  logic [2:0]     pick_idx;
  logic           pick_any;
  logic           release_now;
  logic [W-1:0]   sel_word;

  // In GRANT the search resumes just after the current owner.
  assign pick_ptr = (state_q == GRANT) ? gnt_idx_q : ptr_q;

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  Mux8Way16 u_mux (
    .a   (word_of(data_in, 3'd0)),
    .b   (word_of(data_in, 3'd1)),
    .c   (word_of(data_in, 3'd2)),
    .d   (word_of(data_in, 3'd3)),
    .e   (word_of(data_in, 3'd4)),
    .f   (word_of(data_in, 3'd5)),
    .g   (word_of(data_in, 3'd6)),
    .h   (word_of(data_in, 3'd7)),
    .sel (gnt_idx_q),
    .out (sel_word)
  );

  DMux8Way u_dmux (
    .in  (state_q == GRANT),
    .sel (gnt_idx_q),
    .a   (grant[0]),
    .b   (grant[1]),
    .c   (grant[2]),
    .d   (grant[3]),
    .e   (grant[4]),
    .f   (grant[5]),
    .g   (grant[6]),
    .h   (grant[7])
  );

  assign release_now = !req[gnt_idx_q] || (cnt_q == MAX_HOLD_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          cnt_d     = 4'd1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_d = cnt_q + 4'd1;
        end else if (pick_any) begin
          ptr_d     = gnt_idx_q;
          gnt_idx_d = pick_idx;
          cnt_d     = 4'd1;
        end else begin
          ptr_d   = gnt_idx_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The bus word trails the grant by one edge and holds when not refreshed.
  always_comb begin
    out_valid_d = (state_q == GRANT) && req[gnt_idx_q];
    out_d       = out_valid_d ? sel_word : out_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ptr_q       <= 3'd7;
      gnt_idx_q   <= 3'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = gnt_idx_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Self-checking bench for bus_arbiter8: directed scenarios plus random
// traffic, compared every cycle against a behavioural round-robin model.
module tb_bus_arbiter8;

  logic         clock;
  logic         reset_n;
  logic [7:0]   req;
  logic [127:0] data_in;
  logic [7:0]   grant;
  logic         gnt_valid;
  logic [2:0]   gnt_idx;
  logic [15:0]  out;
  logic         out_valid;

  int checks;
  int failures;

  // Behavioural model state
  bit        m_granted;
  int        m_idx;
  int        m_cnt;
  int        m_ptr;
  bit [15:0] m_out;
  bit        m_outv;

  bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int pick(input logic [7:0] mask, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (mask[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_granted = 0;
    m_idx     = 0;
    m_cnt     = 0;
    m_ptr     = 7;
    m_out     = '0;
    m_outv    = 0;
  endtask

  task automatic model_edge();
    bit rel;
    m_outv = m_granted && req[m_idx];
    if (m_outv) m_out = data_in[16*m_idx +: 16];
    if (!m_granted) begin
      if (req != 0) begin
        m_idx     = pick(req, m_ptr);
        m_cnt     = 1;
        m_granted = 1;
      end
    end else begin
      rel = !req[m_idx] || (m_cnt == 4);
      if (!rel) begin
        m_cnt++;
      end else begin
        m_ptr = m_idx;
        if (req != 0) begin
          m_idx = pick(req, m_idx);
          m_cnt = 1;
        end else begin
          m_granted = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_grant;
    exp_grant = m_granted ? (8'h01 << m_idx) : 8'h00;
    check({tag, ".grant"},     32'(grant),     32'(exp_grant));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_granted));
    check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(m_idx));
    check({tag, ".out"},       32'(out),       32'(m_out));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_outv));
    check({tag, ".onehot0"},   32'($onehot0(grant)), 32'd1);
    check({tag, ".valid_or"},  32'(gnt_valid), 32'(|grant));
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    req      = 8'hFF;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    reset_n  = 1'b1;
    #2;

    // 1: reset behaviour with everyone requesting
    $display("[TB] reset");
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst.grant",     32'(grant),     32'h0);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.out",       32'(out),       32'h0);
    check("rst.gnt_idx",   32'(gnt_idx),   32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cycle("rst_first");
    check("rst_first.direct", 32'(grant), 32'h01);

    // 2: sole requester keeps the bus across MAX_HOLD boundaries
    $display("[TB] sole requester");
    req = 8'h08;
    data_in[16*3 +: 16] = 16'hBEEF;
    for (int i = 0; i < 12; i++) cycle("sole");
    check("sole.direct_out",   32'(out),   32'hBEEF);
    check("sole.direct_grant", 32'(grant), 32'h08);

    // 3: full rotation with everyone requesting
    $display("[TB] all requesting");
    req = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      cycle("all");
    end

    // 4: requester 5 drops early in its burst
    $display("[TB] early drop");
    begin
      int guard = 0;
      while (!(m_granted && m_idx == 5 && m_cnt == 2) && guard < 64) begin
        cycle("drop_seek");
        guard++;
      end
      check("drop.reached", 32'(guard < 64), 32'd1);
    end
    req = 8'h02;
    cycle("drop_1");
    check("drop.direct_grant", 32'(grant), 32'h02);
    check("drop.direct_outv",  32'(out_valid), 32'h0);
    cycle("drop_2");
    check("drop.direct_out", 32'(out), 32'(data_in[16 +: 16]));

    // 5: idle and pointer continuation
    $display("[TB] idle");
    req = 8'h00;
    cycle("idle_1");
    cycle("idle_2");
    req = 8'h40;
    cycle("idle_g6");
    req = 8'h00;
    cycle("idle_3");
    cycle("idle_4");
    req = 8'h01;
    cycle("idle_wake");
    check("idle.direct_grant", 32'(grant), 32'h01);

    // 6: asynchronous reset between edges during a grant
    $display("[TB] mid-cycle reset");
    req = 8'hFF;
    cycle("mid_pre");
    cycle("mid_pre");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid.grant",     32'(grant),     32'h0);
    check("mid.out_valid", 32'(out_valid), 32'h0);
    check("mid.out",       32'(out),       32'h0);
    @(negedge clock);
    req = 8'h81;
    reset_n = 1'b1;
    cycle("mid_first");
    check("mid.direct_grant", 32'(grant), 32'h01);

    // Random traffic
    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) req = 8'h00;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
